// File: rtl/ov5640_capture.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_capture
// Description : OV5640 DVP capture stage. Idles until the sensor is
//               configured, drops SKIP_FRAMES unstable frames, then packs
//               byte pairs into 16-bit RGB565 pixels with frame markers.
//               Runs entirely on the camera pixel clock.
// Ports       : clk, rst           - pixel clock, synchronous active-high reset
//               cfg_done           - sensor configuration complete (level)
//               cam_vsync/href/data- raw DVP inputs
//               pix_data/vld/sop/eop - packed pixel stream toward the FIFO
//               frame_err          - pulse: previous frame had wrong geometry
//               capturing          - high while in the CAPTURE state
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_capture #(
   parameter int SKIP_FRAMES = 10,
   parameter int H_PIXELS    = 640,
   parameter int V_LINES     = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_done,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic [15:0] pix_data,
   output logic        pix_vld,
   output logic        pix_sop,
   output logic        pix_eop,
   output logic        frame_err,
   output logic        capturing
);

   localparam int COL_W  = $clog2(H_PIXELS + 1);
   localparam int LINE_W = $clog2(V_LINES + 1);
   localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
   localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_PIXELS);
   localparam logic [COL_W-1:0]  COL_EOP   = COL_W'(H_PIXELS - 1);
   localparam logic [COL_W-1:0]  COL_MAX   = '1;
   localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);
   localparam logic [LINE_W-1:0] LINE_EOP  = LINE_W'(V_LINES - 1);
   localparam logic [LINE_W-1:0] LINE_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_ALIGN   = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Input stage
   logic        vsync_r1_q, vsync_r2_q, href_r1_q, href_r2_q;
   logic [7:0]  data_r1_q;
   logic        vs_rise, href_fall;

   logic [SKIP_W-1:0] skip_q, skip_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              err_q, err_d;          // geometry error seen in current frame
   logic              sop_pend_q, sop_pend_d; // next emitted pixel starts a frame
   logic [15:0]       pix_data_q, pix_data_d;
   logic              pix_vld_q, pix_vld_d;
   logic              pix_sop_q, pix_sop_d;
   logic              pix_eop_q, pix_eop_d;
   logic              frame_err_q, frame_err_d;
   logic              capturing_q, capturing_d;

   assign vs_rise   = vsync_r1_q & ~vsync_r2_q;
   assign href_fall = href_r2_q & ~href_r1_q;

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      phase_d     = 1'b0;
      hi_d        = hi_q;
      col_d       = col_q;
      line_d      = line_q;
      err_d       = err_q;
      sop_pend_d  = sop_pend_q;
      pix_data_d  = pix_data_q;
      pix_vld_d   = 1'b0;
      pix_sop_d   = 1'b0;
      pix_eop_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            skip_d = '0;
            if (cfg_done) begin
               state_d = (SKIP_FRAMES == 0) ? ST_ALIGN : ST_SKIP;
            end
         end
         ST_SKIP: begin
            // The final counted edge also opens the first captured frame.
            if (vs_rise) begin
               if (skip_q == SKIP_LAST) begin
                  state_d = ST_CAPTURE;
                  skip_d  = '0;
               end else begin
                  skip_d = skip_q + 1'b1;
               end
            end
         end
         ST_ALIGN: begin
            if (vs_rise) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (href_r1_q) begin
               if (!phase_q) begin
                  hi_d    = data_r1_q;
                  phase_d = 1'b1;
               end else begin
                  pix_data_d = {hi_q, data_r1_q};
                  pix_vld_d  = 1'b1;
                  pix_sop_d  = sop_pend_q;
                  sop_pend_d = 1'b0;
                  pix_eop_d  = (col_q == COL_EOP) && (line_q == LINE_EOP);
                  if (col_q >= COL_FULL) begin
                     err_d = 1'b1;
                  end
                  if (col_q != COL_MAX) begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            // Empty href pulses carry no pixels and are not counted as lines.
            if (href_fall) begin
               col_d = '0;
               if (col_q != '0) begin
                  if ((col_q != COL_FULL) || (line_q >= LINE_FULL)) begin
                     err_d = 1'b1;
                  end
                  if (line_q != LINE_MAX) begin
                     line_d = line_q + 1'b1;
                  end
               end
            end
            // A pixel finishing on this cycle still belongs to the old frame.
            if (vs_rise) begin
               frame_err_d = (line_q != LINE_FULL) || err_q;
               col_d       = '0;
               line_d      = '0;
               err_d       = 1'b0;
               sop_pend_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_CAPTURE) begin
         col_d      = '0;
         line_d     = '0;
         err_d      = 1'b0;
         sop_pend_d = 1'b1;
      end

      // Loss of configuration overrides everything else.
      if (!cfg_done) begin
         state_d     = ST_IDLE;
         skip_d      = '0;
         phase_d     = 1'b0;
         col_d       = '0;
         line_d      = '0;
         err_d       = 1'b0;
         sop_pend_d  = 1'b1;
         pix_data_d  = pix_data_q;
         pix_vld_d   = 1'b0;
         pix_sop_d   = 1'b0;
         pix_eop_d   = 1'b0;
         frame_err_d = 1'b0;
      end

      capturing_d = (state_d == ST_CAPTURE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_r1_q  <= 1'b0;
         vsync_r2_q  <= 1'b0;
         href_r1_q   <= 1'b0;
         href_r2_q   <= 1'b0;
         data_r1_q   <= '0;
         state_q     <= ST_IDLE;
         skip_q      <= '0;
         phase_q     <= 1'b0;
         hi_q        <= '0;
         col_q       <= '0;
         line_q      <= '0;
         err_q       <= 1'b0;
         sop_pend_q  <= 1'b1;
         pix_data_q  <= '0;
         pix_vld_q   <= 1'b0;
         pix_sop_q   <= 1'b0;
         pix_eop_q   <= 1'b0;
         frame_err_q <= 1'b0;
         capturing_q <= 1'b0;
      end else begin
         vsync_r1_q  <= cam_vsync;
         vsync_r2_q  <= vsync_r1_q;
         href_r1_q   <= cam_href;
         href_r2_q   <= href_r1_q;
         data_r1_q   <= cam_data;
         state_q     <= state_d;
         skip_q      <= skip_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         col_q       <= col_d;
         line_q      <= line_d;
         err_q       <= err_d;
         sop_pend_q  <= sop_pend_d;
         pix_data_q  <= pix_data_d;
         pix_vld_q   <= pix_vld_d;
         pix_sop_q   <= pix_sop_d;
         pix_eop_q   <= pix_eop_d;
         frame_err_q <= frame_err_d;
         capturing_q <= capturing_d;
      end
   end

   assign pix_data  = pix_data_q;
   assign pix_vld   = pix_vld_q;
   assign pix_sop   = pix_sop_q;
   assign pix_eop   = pix_eop_q;
   assign frame_err = frame_err_q;
   assign capturing = capturing_q;

endmodule
`default_nettype wire

// File: tb/tb_ov5640_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov5640_capture
// Description : Directed self-checking bench for ov5640_capture with a
//               4x2 frame geometry and two skipped frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_capture;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int SKIP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_done;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic [15:0] pix_data;
   logic        pix_vld;
   logic        pix_sop;
   logic        pix_eop;
   logic        frame_err;
   logic        capturing;

   always #5 clk = ~clk;

   ov5640_capture #(
      .SKIP_FRAMES (SKIP),
      .H_PIXELS    (H),
      .V_LINES     (V)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_done  (cfg_done),
      .cam_vsync (cam_vsync),
      .cam_href  (cam_href),
      .cam_data  (cam_data),
      .pix_data  (pix_data),
      .pix_vld   (pix_vld),
      .pix_sop   (pix_sop),
      .pix_eop   (pix_eop),
      .frame_err (frame_err),
      .capturing (capturing)
   );

   int checks = 0;
   int errors = 0;

   // Output log: {sop, eop, data} per emitted pixel, sampled mid-cycle.
   logic [17:0] pix_log [0:255];
   int n_pix  = 0;
   int n_ferr = 0;
   int n_capt = 0;

   always @(negedge clk) begin
      if (pix_vld) begin
         pix_log[n_pix[7:0]] <= {pix_sop, pix_eop, pix_data};
         n_pix <= n_pix + 1;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (capturing) n_capt <= n_capt + 1;
   end

   int b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic line(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         cam_href = 1'b1;
         cam_data = b[7:0];
         b++;
         cyc();
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      idle(3);
   endtask

   // Frame boundary pulse placed after the frame's lines.
   task automatic vpulse();
      idle(2);
      cam_vsync = 1'b1;
      idle(2);
      cam_vsync = 1'b0;
      idle(3);
   endtask

   task automatic frame(input int nlines, input int bpl);
      b = 0;
      for (int l = 0; l < nlines; l++) line(bpl);
      vpulse();
   endtask

   // mode 0/2: consecutive byte pairs; mode 1: first line had 9 bytes.
   task automatic chk_pix(input int base, input int n, input int mode);
      for (int k = 0; k < n; k++) begin
         int hi;
         logic [17:0] e;
         hi = (mode == 1 && k >= 4) ? 2 * k + 1 : 2 * k;
         e  = {(k == 0), (k == 7), 8'(hi), 8'(hi + 1)};
         chk($sformatf("pix%0d", base + k), {14'd0, pix_log[base + k]}, {14'd0, e});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      cfg_done  = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      b         = 0;
      idle(3);
      chk("rst_vld",  {31'd0, pix_vld},   32'd0);
      chk("rst_sop",  {31'd0, pix_sop},   32'd0);
      chk("rst_eop",  {31'd0, pix_eop},   32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_capt", {31'd0, capturing}, 32'd0);
      chk("rst_data", {16'd0, pix_data},  32'd0);
      rst = 1'b0;

      // Unconfigured sensor: frames run, nothing may come out.
      frame(2, 8);
      frame(2, 8);
      chk("idle_npix", n_pix,  0);
      chk("idle_capt", n_capt, 0);

      // Configured: two frames discarded, then capture.
      cfg_done = 1'b1;
      frame(2, 8);
      frame(2, 8);
      chk("skip_npix", n_pix, 0);
      chk("skip_capt", {31'd0, capturing}, 32'd1);
      frame(2, 8);
      chk("f3_npix", n_pix, 8);
      chk_pix(0, 8, 0);
      frame(2, 8);
      chk("f4_npix", n_pix, 16);
      chk_pix(8, 8, 0);
      chk("f4_ferr", n_ferr, 0);

      // Odd byte count on the first line.
      b = 0;
      line(9);
      line(8);
      vpulse();
      chk("odd_npix", n_pix, 24);
      chk_pix(16, 8, 1);
      chk("odd_ferr", n_ferr, 0);

      // Three lines: one extra line, eop only on the expected last pixel.
      frame(3, 8);
      chk("big_npix", n_pix, 36);
      chk_pix(24, 12, 2);
      chk("big_ferr", n_ferr, 1);
      frame(2, 8);
      chk("after_big_npix", n_pix, 44);
      chk_pix(36, 8, 0);
      chk("after_big_ferr", n_ferr, 1);

      // cfg_done drops mid-line.
      for (int i = 0; i < 8; i++) begin
         cam_href = 1'b1;
         cam_data = 8'(i);
         if (i == 5) cfg_done = 1'b0;
         cyc();
         if (i == 4) chk("pre_drop_vld", {31'd0, pix_vld}, 32'd1);
         if (i == 5) begin
            chk("drop_vld",  {31'd0, pix_vld},   32'd0);
            chk("drop_capt", {31'd0, capturing}, 32'd0);
         end
      end
      cam_href = 1'b0;
      idle(3);
      b = 0;
      line(8);
      vpulse();
      chk("drop_npix", n_pix, 46);
      chk("drop_p0", {14'd0, pix_log[44]}, {14'd0, 2'b10, 16'h0001});
      chk("drop_p1", {14'd0, pix_log[45]}, {14'd0, 2'b00, 16'h0203});
      cfg_done = 1'b1;
      frame(2, 8);
      frame(2, 8);
      chk("recfg_skip_npix", n_pix, 46);
      frame(2, 8);
      chk("recfg_npix", n_pix, 54);
      chk_pix(46, 8, 0);

      // One-cycle reset mid-line.
      b = 0;
      for (int i = 0; i < 8; i++) begin
         cam_href = 1'b1;
         cam_data = b[7:0];
         b++;
         if (i == 3) rst = 1'b1;
         cyc();
         if (i == 2) chk("pre_rst_data", {16'd0, pix_data}, 32'h0001);
         if (i == 3) begin
            chk("mrst_vld",  {31'd0, pix_vld},   32'd0);
            chk("mrst_data", {16'd0, pix_data},  32'd0);
            chk("mrst_sop",  {31'd0, pix_sop},   32'd0);
            chk("mrst_eop",  {31'd0, pix_eop},   32'd0);
            chk("mrst_ferr", {31'd0, frame_err}, 32'd0);
            chk("mrst_capt", {31'd0, capturing}, 32'd0);
            rst = 1'b0;
         end
      end
      cam_href = 1'b0;
      idle(3);
      line(8);
      vpulse();
      chk("mrst_skip_capt", {31'd0, capturing}, 32'd0);
      frame(2, 8);
      chk("mrst_npix_skip", n_pix, 55);
      frame(2, 8);
      chk("mrst_npix", n_pix, 63);
      chk_pix(55, 8, 0);
      chk("final_ferr", n_ferr, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ov5640_capture.md
Name: ov5640_capture

Overview:
- DVP capture stage directly downstream of ov5640_config; held idle until the sensor is configured (cfg_done).
- Discards SKIP_FRAMES unstable frames after configuration, then aligns to a frame boundary.
- Packs two 8-bit DVP bytes into one 16-bit RGB565 pixel and emits a valid-qualified pixel stream with frame markers toward the SDRAM write FIFO.
- Runs entirely on the camera pixel clock.

Parameters:
- SKIP_FRAMES, 10: complete frames discarded after cfg_done before capture starts (0 allowed).
- H_PIXELS, 640: expected pixels per line (16-bit pixels, i.e. 2*H_PIXELS bytes).
- V_LINES, 480: expected lines per frame.

Ports:
- clk  input  1: camera pixel clock (PCLK); sole clock.
- rst  input  1: synchronous, active-high reset.
- cfg_done  input  1: level; high once sensor register configuration has completed.
- cam_vsync  input  1: frame sync, active high; its rising edge marks a frame boundary.
- cam_href  input  1: line valid, active high.
- cam_data  input  8: DVP data byte, sampled on clk rising edge.
- pix_data  output  16: RGB565 pixel; first byte of the pair in [15:8], second byte in [7:0].
- pix_vld  output  1: one-cycle strobe, pix_data valid.
- pix_sop  output  1: coincident with pix_vld on the first pixel of a frame.
- pix_eop  output  1: coincident with pix_vld on pixel (H_PIXELS-1, V_LINES-1).
- frame_err  output  1: one-cycle pulse, captured frame size mismatch.
- capturing  output  1: high in CAPTURE state.

Behaviour:
- Input stage: cam_vsync, cam_href and cam_data are registered once (stage r1). vsync_r2 is a delayed copy used for edge detection. vs_rise = vsync_r1 & ~vsync_r2. href_fall is detected the same way.
- Reset values:
  - All outputs 0; pix_data 0.
  - State IDLE; skip, byte-phase, column and line counters 0.
- State machine:
  - IDLE: wait for cfg_done=1, then go to SKIP. If SKIP_FRAMES=0, go directly to ALIGN.
  - SKIP: count vs_rise. On the SKIP_FRAMES-th vs_rise, go to CAPTURE. That edge is the start of the first captured frame, so there is no separate wait.
  - ALIGN: used only when SKIP_FRAMES=0. Wait for vs_rise, then go to CAPTURE.
  - CAPTURE: pack pixels. Remains in CAPTURE across frames.
  - From any state, cfg_done=0 returns the block to IDLE on the next clock. All counters clear and no further pix_vld is issued.
- Byte packing (CAPTURE only):
  - While href_r1=1, bytes alternate phase 0/1.
  - Phase 0: latch byte into the high half.
  - Phase 1: pix_data <= {high, byte} and pix_vld=1 on the next clock.
  - Latency: pix_vld is asserted 2 clocks after the second byte of the pair is present on cam_data.
  - href_r1=0 resets the phase to 0. An orphan odd byte at line end is dropped silently.
- Counters:
  - col increments per emitted pixel and is cleared on href_fall.
  - line increments on href_fall and only if col != 0 (empty href pulses are ignored).
  - Both counters clear on vs_rise.
  - Widths are $clog2(H_PIXELS+1) and $clog2(V_LINES+1); counters saturate at max and never wrap.
- Frame markers:
  - pix_sop: first pix_vld after vs_rise in CAPTURE.
  - pix_eop: pix_vld when col==H_PIXELS-1 and line==V_LINES-1.
  - Extra pixels or lines beyond the expected size are still output; they never produce pix_sop or pix_eop.
- frame_err: pulses on vs_rise in CAPTURE when the frame just ended had line != V_LINES, or when any line had col != H_PIXELS at href_fall (sticky per frame, cleared on vs_rise). The first vs_rise on entering CAPTURE never flags an error.
- Simultaneous events:
  - vs_rise in the same cycle as a phase-1 byte: the pixel is still emitted and counted in the old frame, then counters clear.
  - cfg_done falling has priority over all other events.
- Reset mid-frame: returns to IDLE. The next capture begins only after cfg_done, the skip count, and a fresh vsync edge.
- capturing: registered, equals (state==CAPTURE).

Test Plan:
- Params H=4, V=2, SKIP=2; cfg_done held 0 with frames running -> pix_vld never asserted, capturing=0.
- cfg_done=1, 4 frames of bytes 0x00..0x0F per frame -> frames 1-2 discarded. Frame 3 yields 8 pixels 0x0001, 0x0203, ..., 0x0E0F, with pix_sop on the first and pix_eop on the eighth. frame_err stays 0.
- Line with 9 bytes (odd) -> 4 pixels emitted, 9th byte dropped. The next line's first pixel is formed from its own bytes 0 and 1.
- Frame with 3 lines of 4 pixels -> 12 pix_vld, pix_eop on the 8th only, frame_err pulses once at the following vsync rising edge.
- cfg_done drops mid-line while capturing -> pix_vld stops within 1 clock. Re-asserting cfg_done requires 2 skipped frames before output resumes.
- rst=1 for one cycle mid-frame -> all outputs 0 the next cycle. Behaviour afterwards matches the second scenario.
